// File: rtl/dds_chirp_pkg.sv
// Shared state and osk-mode encodings for the DDS chirp sequencer.
// Optional wait-for-drover timeout is enabled with `define DDS_TIMEOUT_EN.
package dds_chirp_pkg;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] WAIT_DROVER = 2'd1;
    localparam logic [1:0] HALF1       = 2'd2;
    localparam logic [1:0] HALF2       = 2'd3;

    localparam logic [1:0] OSK_OFF    = 2'b00;
    localparam logic [1:0] OSK_FIRST  = 2'b01;
    localparam logic [1:0] OSK_SECOND = 2'b10;
    localparam logic [1:0] OSK_BOTH   = 2'b11;

    function automatic logic osk_in_half1(input logic [1:0] mode);
        return (mode == OSK_FIRST) || (mode == OSK_BOTH);
    endfunction

    function automatic logic osk_in_half2(input logic [1:0] mode);
        return (mode == OSK_SECOND) || (mode == OSK_BOTH);
    endfunction

endpackage

// File: rtl/dds_chirp_sequencer_channel.sv
// One DDS channel: input synchronisers, chirp FSM, counters and shadow config.
// `define DDS_TIMEOUT_EN adds the wait-for-drover timeout and sticky error flag.
module dds_chirp_channel
    import dds_chirp_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned CLKNUM  = 2,
    parameter int unsigned BURST_W = 8,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   pulse,
    input  logic [1:0]         mode,
    input  logic [BURST_W-1:0] burst,
    input  logic               io_update,
    input  logic               drover,
    input  logic               err_clr,
    output logic               drctl,
    output logic               osk,
    output logic               busy,
    output logic               timeout_err
);

    logic [2:0]         io_sync;
    logic [2:0]         dr_sync;
    logic               io_rise;
    logic               dr_fall;
    logic [CNT_W-1:0]   full;
    logic [CNT_W-1:0]   half;
    logic [BURST_W-1:0] burst_eff;
    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   full_s;
    logic [CNT_W-1:0]   half_s;
    logic [1:0]         mode_s;
    logic [BURST_W-1:0] burst_rem;
    logic               tmo_hit;

    // Edge pulses are registered so an edge first sampled at k moves the FSM at k+3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_sync <= '0;
            dr_sync <= '0;
            io_rise <= 1'b0;
            dr_fall <= 1'b0;
        end else begin
            io_sync <= {io_sync[1:0], io_update};
            dr_sync <= {dr_sync[1:0], drover};
            io_rise <= io_sync[1] & ~io_sync[2];
            dr_fall <= ~dr_sync[1] & dr_sync[2];
        end
    end

    assign full      = pulse / CNT_W'(CLKNUM);
    assign half      = full >> 1;
    assign burst_eff = (burst == '0) ? BURST_W'(1) : burst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            full_s    <= '0;
            half_s    <= '0;
            mode_s    <= OSK_OFF;
            burst_rem <= '0;
            drctl     <= 1'b0;
            osk       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_rise && (half != '0)) begin
                        state     <= WAIT_DROVER;
                        full_s    <= full;
                        half_s    <= half;
                        mode_s    <= mode;
                        burst_rem <= burst_eff;
                        drctl     <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                WAIT_DROVER: begin
                    if (dr_fall) begin
                        state <= HALF1;
                        cnt   <= '0;
                        osk   <= osk_in_half1(mode_s);
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        drctl <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                HALF1: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == half_s - CNT_W'(1)) begin
                        state <= HALF2;
                        drctl <= 1'b0;
                        osk   <= osk_in_half2(mode_s);
                    end
                end
                HALF2: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == full_s - CNT_W'(1)) begin
                        burst_rem <= burst_rem - BURST_W'(1);
                        osk       <= 1'b0;
                        // Re-entering WAIT_DROVER directly keeps bursts free of idle cycles.
                        if (burst_rem != BURST_W'(1)) begin
                            state <= WAIT_DROVER;
                            drctl <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    drctl <= 1'b0;
                    osk   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DDS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state == WAIT_DROVER) && !dr_fall &&
                     (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Held at zero outside WAIT_DROVER, so every entry (including between chirps) restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != WAIT_DROVER) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (tmo_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end
`else
    logic unused_err_clr;

    assign tmo_hit        = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_err_clr = err_clr;
`endif

endmodule

// File: rtl/dds_chirp_sequencer.sv
// Multi-channel AD9910 chirp timing sequencer; one independent channel per DDS.
// `define DDS_TIMEOUT_EN enables the per-channel wait-for-drover timeout.
module dds_chirp_sequencer
    import dds_chirp_pkg::*;
#(
    parameter int unsigned CH_NUM  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned CLKNUM  = 2,
    parameter int unsigned BURST_W = 8,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [CH_NUM*CNT_W-1:0]   cfg_pulse,
    input  logic [CH_NUM*2-1:0]       cfg_mode,
    input  logic [CH_NUM*BURST_W-1:0] cfg_burst,
    input  logic [CH_NUM-1:0]         io_update,
    input  logic [CH_NUM-1:0]         drover,
    input  logic                      err_clr,
    output logic [CH_NUM-1:0]         drctl,
    output logic [CH_NUM-1:0]         osk,
    output logic [CH_NUM-1:0]         busy,
    output logic [CH_NUM-1:0]         timeout_err
);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        dds_chirp_channel #(
            .CNT_W   (CNT_W),
            .CLKNUM  (CLKNUM),
            .BURST_W (BURST_W),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk         (sys_clk),
            .rst_n       (sys_rst_n),
            .pulse       (cfg_pulse[i*CNT_W +: CNT_W]),
            .mode        (cfg_mode[i*2 +: 2]),
            .burst       (cfg_burst[i*BURST_W +: BURST_W]),
            .io_update   (io_update[i]),
            .drover      (drover[i]),
            .err_clr     (err_clr),
            .drctl       (drctl[i]),
            .osk         (osk[i]),
            .busy        (busy[i]),
            .timeout_err (timeout_err[i])
        );
    end

endmodule

// File: tb/tb_dds_chirp_sequencer.sv
// Directed self-checking bench for dds_chirp_sequencer (two channels, TIMEOUT = 100).
// Timeout checks compile in only when DDS_TIMEOUT_EN is defined.
module tb_dds_chirp_sequencer;

    localparam int NONE = 9999;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [31:0] cfg_pulse;
    logic [3:0]  cfg_mode;
    logic [15:0] cfg_burst;
    logic [1:0]  io_update;
    logic [1:0]  drover;
    logic        err_clr;
    logic [1:0]  drctl;
    logic [1:0]  osk;
    logic [1:0]  busy;
    logic [1:0]  timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    int osk_first  [2];
    int osk_cnt    [2];
    int drctl_fall [2];
    int drctl_rise [2];
    int busy_fall  [2];

    dds_chirp_sequencer #(
        .CH_NUM  (2),
        .CNT_W   (16),
        .CLKNUM  (2),
        .BURST_W (8),
        .TIMEOUT (100)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cfg_pulse   (cfg_pulse),
        .cfg_mode    (cfg_mode),
        .cfg_burst   (cfg_burst),
        .io_update   (io_update),
        .drover      (drover),
        .err_clr     (err_clr),
        .drctl       (drctl),
        .osk         (osk),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int ch, input int pulse, input logic [1:0] mode, input int burst);
        cfg_pulse[ch*16 +: 16] = 16'(pulse);
        cfg_mode[ch*2 +: 2]    = mode;
        cfg_burst[ch*8 +: 8]   = 8'(burst);
    endtask

    // Drive io_update at a negedge; the next posedge is k, busy must appear at k+3, not k+2.
    task automatic arm(input logic [1:0] mask, input logic exp);
        io_update = io_update | mask;
        repeat (2) @(negedge sys_clk);
        io_update = io_update & ~mask;
        @(negedge sys_clk);
        check("arm_latency_busy", int'(busy & mask), 0);
        @(negedge sys_clk);
        check("arm_busy", int'(busy & mask), exp ? int'(mask) : 0);
        check("arm_drctl", int'(drctl & mask), exp ? int'(mask) : 0);
    endtask

    // Sample i is taken after the (i+1)-th posedge following the drover fall; HALF1 shows at i=3.
    task automatic chirp(input logic [1:0] mask, input int n);
        for (int c = 0; c < 2; c++) begin
            osk_first[c]  = NONE;
            osk_cnt[c]    = 0;
            drctl_fall[c] = NONE;
            drctl_rise[c] = NONE;
            busy_fall[c]  = NONE;
        end
        drover = drover | mask;
        repeat (4) @(negedge sys_clk);
        drover = drover & ~mask;
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            for (int c = 0; c < 2; c++) begin
                if (osk[c]) begin
                    osk_cnt[c]++;
                    if (osk_first[c] == NONE) osk_first[c] = i;
                end
                if (!drctl[c] && drctl_fall[c] == NONE) drctl_fall[c] = i;
                else if (drctl[c] && drctl_fall[c] != NONE && drctl_rise[c] == NONE) drctl_rise[c] = i;
                if (!busy[c] && busy_fall[c] == NONE) busy_fall[c] = i;
            end
        end
    endtask

    logic [1:0] mode_tab  [3] = '{2'b10, 2'b11, 2'b00};
    int         first_tab [3] = '{253, 3, NONE};
    int         cnt_tab   [3] = '{250, 500, 0};

    initial begin
        sys_rst_n = 1'b0;
        cfg_pulse = '0;
        cfg_mode  = '0;
        cfg_burst = '0;
        io_update = '0;
        drover    = '0;
        err_clr   = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_drctl", int'(drctl), 0);
        check("rst_osk", int'(osk), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Single chirp, mode 01: full = 500, half = 250
        set_cfg(0, 1000, 2'b01, 1);
        arm(2'b01, 1'b1);
        chirp(2'b01, 510);
        check("single_osk_first", osk_first[0], 3);
        check("single_osk_cnt", osk_cnt[0], 250);
        check("single_drctl_fall", drctl_fall[0], 253);
        check("single_busy_fall", busy_fall[0], 503);
        check("single_ch1_idle", busy_fall[1], 0);

        for (int m = 0; m < 3; m++) begin
            set_cfg(0, 1000, mode_tab[m], 1);
            arm(2'b01, 1'b1);
            chirp(2'b01, 510);
            check("mode_osk_first", osk_first[0], first_tab[m]);
            check("mode_osk_cnt", osk_cnt[0], cnt_tab[m]);
            check("mode_busy_fall", busy_fall[0], 503);
        end

        // Burst of 3, pulse 200: full = 100, half = 50
        set_cfg(0, 200, 2'b11, 3);
        arm(2'b01, 1'b1);
        for (int b = 0; b < 3; b++) begin
            chirp(2'b01, 110);
            check("burst_drctl_fall", drctl_fall[0], 53);
            check("burst_osk_cnt", osk_cnt[0], 100);
            check("burst_drctl_rise", drctl_rise[0], (b < 2) ? 103 : NONE);
            check("burst_busy_fall", busy_fall[0], (b < 2) ? NONE : 103);
        end

        // Unprogrammed pulse is ignored
        set_cfg(0, 0, 2'b01, 1);
        arm(2'b01, 1'b0);

        // Pulse 6: full = 3, half = 1; burst 0 acts as 1
        set_cfg(0, 6, 2'b01, 0);
        arm(2'b01, 1'b1);
        chirp(2'b01, 12);
        check("p6_osk_first", osk_first[0], 3);
        check("p6_osk_cnt", osk_cnt[0], 1);
        check("p6_drctl_fall", drctl_fall[0], 4);
        check("p6_busy_fall", busy_fall[0], 6);

        // Re-arm and config change mid-chirp must not disturb the pulse in progress
        set_cfg(0, 200, 2'b11, 1);
        arm(2'b01, 1'b1);
        fork
            chirp(2'b01, 110);
            begin
                repeat (20) @(negedge sys_clk);
                io_update[0] = 1'b1;
                set_cfg(0, 1000, 2'b01, 5);
                repeat (2) @(negedge sys_clk);
                io_update[0] = 1'b0;
            end
        join
        check("rearm_osk_cnt", osk_cnt[0], 100);
        check("rearm_busy_fall", busy_fall[0], 103);
        repeat (10) @(negedge sys_clk);
        check("rearm_stays_idle", int'(busy[0]), 0);

`ifdef DDS_TIMEOUT_EN
        begin
            int tmo_first;
            set_cfg(0, 200, 2'b01, 1);
            arm(2'b01, 1'b1);
            tmo_first = NONE;
            for (int j = 1; j <= 120; j++) begin
                @(negedge sys_clk);
                if (timeout_err[0] && tmo_first == NONE) tmo_first = j;
                if (j == 100) begin
                    check("tmo_drctl", int'(drctl[0]), 0);
                    check("tmo_busy", int'(busy[0]), 0);
                end
            end
            check("tmo_first", tmo_first, 100);
            err_clr = 1'b1;
            @(negedge sys_clk);
            err_clr = 1'b0;
            check("tmo_cleared", int'(timeout_err[0]), 0);
            arm(2'b01, 1'b1);
            repeat (99) @(negedge sys_clk);
            check("tmo_pre_set", int'(timeout_err[0]), 0);
            err_clr = 1'b1;
            @(negedge sys_clk);
            err_clr = 1'b0;
            check("tmo_set_wins", int'(timeout_err[0]), 1);
        end
`else
        set_cfg(0, 200, 2'b01, 1);
        arm(2'b01, 1'b1);
        repeat (150) @(negedge sys_clk);
        check("wait_hold_busy", int'(busy[0]), 1);
        check("wait_hold_drctl", int'(drctl[0]), 1);
        check("wait_hold_err", int'(timeout_err[0]), 0);
        chirp(2'b01, 110);
        check("wait_hold_busy_fall", busy_fall[0], 103);
`endif

        // Asynchronous reset mid-HALF1 discards the remaining burst
        set_cfg(0, 1000, 2'b11, 2);
        arm(2'b01, 1'b1);
        drover[0] = 1'b1;
        repeat (4) @(negedge sys_clk);
        drover[0] = 1'b0;
        repeat (10) @(negedge sys_clk);
        check("pre_rst_osk", int'(osk[0]), 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_drctl", int'(drctl), 0);
        check("async_rst_osk", int'(osk), 0);
        check("async_rst_busy", int'(busy), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        chirp(2'b01, 20);
        check("post_rst_osk_cnt", osk_cnt[0], 0);
        check("post_rst_busy_fall", busy_fall[0], 0);

        // Both channels together with different pulses and modes
        set_cfg(0, 1000, 2'b01, 1);
        set_cfg(1, 200, 2'b10, 1);
        arm(2'b11, 1'b1);
        chirp(2'b11, 510);
        check("iso0_osk_first", osk_first[0], 3);
        check("iso0_osk_cnt", osk_cnt[0], 250);
        check("iso0_drctl_fall", drctl_fall[0], 253);
        check("iso0_busy_fall", busy_fall[0], 503);
        check("iso1_osk_first", osk_first[1], 53);
        check("iso1_osk_cnt", osk_cnt[1], 50);
        check("iso1_drctl_fall", drctl_fall[1], 53);
        check("iso1_busy_fall", busy_fall[1], 103);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
